mips_cpu_mem_if: RTL
====================

// Module: mips_cpu_mem_if
// PURPOSE
//  Parametrised Avalon-MM master load/store unit between the multicycle MIPS core and the bus.
//  Honours waitrequest, configurable read latency and an optional stall timeout.
//  Steers byte lanes for LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW (little-endian) and sign/zero-extends.
//  Core issues one request at a time (valid/ready); unit returns a single-cycle response pulse.
// PARAMETERS
//  ADDR_W        32  byte-address width; bus address is always word-aligned (addr[1:0]=0)
//  DATA_W        32  bus data width; fixed at 32 in this revision, checked by elaboration assert
//  READ_LATENCY  1   cycles from read acceptance (waitrequest low) to readdata valid; legal 1..4
//  MAX_WAIT      0   0 = wait forever; N>0 = error after N consecutive waitrequest-high cycles
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       core request present
//  req_ready    out  1       unit idle, request accepted when req_valid && req_ready
//  req_op       in   4       mem_op_t: LB,LBU,LH,LHU,LW,LWL,LWR,SB,SH,SW
//  req_addr     in   ADDR_W  effective byte address
//  req_wdata    in   DATA_W  store data (rt), right-justified
//  req_rt_old   in   DATA_W  current rt value, merge source for LWL/LWR
//  resp_valid   out  1       one-cycle pulse: access complete
//  resp_rdata   out  DATA_W  formatted load result (0 for stores/errors)
//  resp_err     out  1       with resp_valid: misaligned or timeout
//  address      out  ADDR_W  Avalon address, {req_addr[ADDR_W-1:2],2'b00}
//  read         out  1       Avalon read
//  write        out  1       Avalon write
//  waitrequest  in   1       Avalon stall
//  writedata    out  DATA_W  lane-steered store data
//  byteenable   out  4       active lanes
//  readdata     in   DATA_W  Avalon read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 (from cycle after rst low), read=write=0, byteenable=0,
//   resp_valid=0, resp_err=0, resp_rdata=0. rst mid-access aborts it: bus strobes drop next cycle.
//  FSM IDLE->ACCESS on accept (request registered); IDLE->RESP_ERR if misaligned (no bus cycle).
//  ACCESS: read or write held with stable address/writedata/byteenable while waitrequest=1.
//   waitrequest=0: write -> RESP; read -> WAIT_DATA with latency counter = READ_LATENCY-1.
//   MAX_WAIT>0 and stall counter reaches MAX_WAIT -> strobes drop, RESP_ERR.
//  WAIT_DATA: counts down; readdata captured when counter is 0 -> RESP.
//  RESP / RESP_ERR: resp_valid=1 one cycle, then IDLE. req_ready=1 only in IDLE.
//  Latency, zero-wait, READ_LATENCY=1: accept c0, read c1, data c2, resp_valid c3. Store: resp c2.
//  Misaligned: LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0. Byte ops and LWL/LWR never misaligned.
//  Lanes, k=addr[1:0]: SB be=1<<k, wdata[7:0] in lane k; SH be=0011/1100; SW be=1111.
//   Loads always byteenable=1111; lane select and extension applied on capture.
//  LWL: rt bytes[3:3-k] <- mem bytes[k:0], rest from req_rt_old.
//   LWR: rt bytes[3-k:0] <- mem bytes[3:k], rest from req_rt_old.
//  read and write never both 1; req_valid outside IDLE ignored (no queueing).
// STRUCTURE
//  Package mips_cpu_pkg: mem_op_t enum, mem-if state_t enum, opcode constants shared with core.
//  Sub-module mips_cpu_mem_align (combinational): store lane steering + byteenable, load
//   extract/extend/LWL-LWR merge. FSM, counters and registers stay in mips_cpu_mem_if.
// TESTING
//  LB addr 0x1003, readdata 0x80FF_FF00 -> resp_rdata 0xFFFF_FF80, address 0x1000, resp at c3.
//  SH addr 0x2002 wdata 0x0000_BEEF, waitrequest high 3 cycles -> write held 4 cycles,
//   be=1100, writedata[31:16]=0xBEEF, resp_valid 1 cycle after release.
//  LW addr 0x3001 -> no read strobe, resp_valid c1 with resp_err=1.
//  LWL addr 0x4001, readdata 0x4433_2211, rt_old 0xAABB_CCDD -> 0x2211_CCDD;
//   LWR same addr -> 0xAA44_3322.
//  MAX_WAIT=8, waitrequest stuck high -> read drops after 8 stall cycles, resp_err=1; READ_LATENCY=3 LW resp at c5.
//  rst asserted in ACCESS during stall -> read=0 next cycle, no resp_valid, req_ready=1 after rst.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multicycle MIPS core and its memory unit.
//   mem_op_t      : load/store flavour handed from the core to mips_cpu_mem_if
//   state_t       : mips_cpu_mem_if FSM state
//   OPC_*         : primary opcodes of the memory instructions (decoded by the core)
//   is_store      : true for SB/SH/SW
//   is_misaligned : alignment rule for halfword/word accesses
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_LWL,
        OP_LWR,
        OP_SB,
        OP_SH,
        OP_SW
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT_DATA,
        ST_RESP,
        ST_RESP_ERR
    } state_t;

    localparam logic [5:0] OPC_LB  = 6'h20;
    localparam logic [5:0] OPC_LH  = 6'h21;
    localparam logic [5:0] OPC_LWL = 6'h22;
    localparam logic [5:0] OPC_LW  = 6'h23;
    localparam logic [5:0] OPC_LBU = 6'h24;
    localparam logic [5:0] OPC_LHU = 6'h25;
    localparam logic [5:0] OPC_LWR = 6'h26;
    localparam logic [5:0] OPC_SB  = 6'h28;
    localparam logic [5:0] OPC_SH  = 6'h29;
    localparam logic [5:0] OPC_SW  = 6'h2B;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Byte accesses and LWL/LWR are never misaligned.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = a[0];
            OP_LW, OP_SW:         mis = (a != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_cpu_mem_if_if.sv
// Signal bundle between the core, the memory unit and the Avalon-MM bus.
//   Core side : req_valid/req_ready/req_op/req_addr/req_wdata/req_rt_old,
//               resp_valid/resp_rdata/resp_err
//   Bus side  : address/read/write/writedata/byteenable (unit drives),
//               waitrequest/readdata (bus drives)
//   modport master : the memory unit's view
//   modport slave  : the environment's view (core + bus fabric)
interface mips_cpu_mem_if_if
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    mem_op_t           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_rt_old;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [DATA_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] readdata;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rt_old, waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rt_old, waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               address, read, write, writedata, byteenable
    );

endinterface

// File: rtl/mips_cpu_mem_align.sv
// Combinational little-endian byte-lane logic for the memory unit.
//   op_i, addr_lo_i : registered operation and byte offset within the word
//   wdata_i         : right-justified store data
//   rdata_i         : raw bus read data
//   rt_old_i        : previous rt value, merge source for LWL/LWR
//   be_o            : byteenable (stores steered, loads always 1111)
//   wdata_o         : lane-steered store data
//   load_o          : extracted, extended or merged load result
module mips_cpu_mem_align
    import mips_cpu_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] rt_old_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [5:0]  sh;
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        sh      = {1'b0, addr_lo_i, 3'b000};
        byte_w  = rdata_i[sh[4:0] +: 8];
        half_w  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        load_o  = rdata_i;
        case (op_i)
            // Replicating the narrow datum puts it in every lane; byteenable picks the one.
            OP_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            OP_LB:  load_o = {{24{byte_w[7]}}, byte_w};
            OP_LBU: load_o = {24'h0, byte_w};
            OP_LH:  load_o = {{16{half_w[15]}}, half_w};
            OP_LHU: load_o = {16'h0, half_w};
            // LWL: mem bytes [k:0] land in rt bytes [3:3-k]; lower rt bytes kept.
            OP_LWL: load_o = (rdata_i << (6'd24 - sh)) |
                             (rt_old_i & (32'hFFFF_FFFF >> (sh + 6'd8)));
            // LWR: mem bytes [3:k] land in rt bytes [3-k:0]; upper rt bytes kept.
            OP_LWR: load_o = (rdata_i >> sh) |
                             (rt_old_i & ~(32'hFFFF_FFFF >> sh));
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_if.sv
// Avalon-MM master load/store unit for the multicycle MIPS core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mips_cpu_mem_if_if.master -- core request/response handshake plus
//              Avalon address/read/write/writedata/byteenable/waitrequest/readdata
// One request at a time; a single-cycle resp_valid pulse ends each access.
// READ_LATENCY (1..4) is the fixed read pipeline depth; MAX_WAIT>0 enables a stall timeout.
module mips_cpu_mem_if
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 0
) (
    input  logic clk,
    input  logic rst,
    mips_cpu_mem_if_if.master bus
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mips_cpu_mem_if: DATA_W must be 32");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("mips_cpu_mem_if: READ_LATENCY must be 1..4");
    end

    localparam int STALL_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_t             state_q,  state_d;
    mem_op_t            op_q,     op_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [DATA_W-1:0]  wdata_q,  wdata_d;
    logic [DATA_W-1:0]  rt_old_q, rt_old_d;
    logic [DATA_W-1:0]  rdata_q,  rdata_d;
    logic [STALL_W-1:0] stall_q,  stall_d;
    logic [1:0]         lat_q,    lat_d;

    logic [3:0]        be_w;
    logic [DATA_W-1:0] wdata_w;
    logic [DATA_W-1:0] load_w;

    mips_cpu_mem_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.readdata),
        .rt_old_i  (rt_old_q),
        .be_o      (be_w),
        .wdata_o   (wdata_w),
        .load_o    (load_w)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rt_old_d = rt_old_q;
        rdata_d  = rdata_q;
        stall_d  = stall_q;
        lat_d    = lat_q;

        bus.req_ready  = (state_q == ST_IDLE) && !rst;
        bus.resp_valid = (state_q == ST_RESP) || (state_q == ST_RESP_ERR);
        bus.resp_err   = (state_q == ST_RESP_ERR);
        bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
        bus.address    = {addr_q[ADDR_W-1:2], 2'b00};
        bus.read       = (state_q == ST_ACCESS) && !is_store(op_q);
        bus.write      = (state_q == ST_ACCESS) &&  is_store(op_q);
        bus.byteenable = (state_q == ST_ACCESS) ? be_w : 4'b0000;
        bus.writedata  = wdata_w;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rt_old_d = bus.req_rt_old;
                    rdata_d  = '0;
                    stall_d  = '0;
                    state_d  = is_misaligned(bus.req_op, bus.req_addr[1:0]) ? ST_RESP_ERR
                                                                             : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!bus.waitrequest) begin
                    if (is_store(op_q)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT_DATA;
                        lat_d   = 2'(READ_LATENCY - 1);
                    end
                end else if ((MAX_WAIT > 0) && (stall_q == STALL_W'(MAX_WAIT - 1))) begin
                    state_d = ST_RESP_ERR;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            ST_WAIT_DATA: begin
                if (lat_q == 2'd0) begin
                    rdata_d = load_w;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_RESP, ST_RESP_ERR: state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_old_q <= '0;
            rdata_q  <= '0;
            stall_q  <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_old_q <= rt_old_d;
            rdata_q  <= rdata_d;
            stall_q  <= stall_d;
            lat_q    <= lat_d;
        end
    end

endmodule
